cell_packet_receiver: RTL and testbench

Consumes the 32-bit RX AXI stream produced by the Aurora link (data, keep, user CRC flags, last, valid; no backpressure). Parses cell packets, stores each one speculatively in a circular buffer, and commits it only when the final beat reports a good CRC. Framing errors, bad CRC and overflow are rolled back and counted. Committed packets are replayed on a back-pressurable 32-bit AXI stream to the cell controller.

---
 rtl/cell_packet_receiver.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_cell_packet_receiver.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_packet_receiver.sv
// rtl/cell_packet_receiver.sv - speculative-commit cell packet receiver with replay stream
//
// Purpose:
//   Parses cell packets from the Aurora RX stream, stores each one
//   speculatively in a circular buffer and commits it only when the final
//   beat reports a good CRC. Framing errors, bad CRC and lack of space roll
//   the packet back and bump a saturating counter. Committed words are
//   replayed on a back-pressurable stream through a 2-entry output queue.
//
// Ports:
//   auUserClk        single clock
//   auUserReset      synchronous, active-high reset
//   sAxisT*          RX stream (data, keep, user CRC flags, last, valid), no ready
//   mAxisT*          committed packet stream, header word first
//   goodPktCount     committed packets (saturating)
//   crcErrCount      packets dropped for CRC (saturating)
//   framingErrCount  packets dropped for framing (saturating)
//   overflowCount    packets dropped for lack of space (saturating)
//   busy             receive FSM is not idle
module cell_packet_receiver #(
  parameter int         ADDR_WIDTH = 9,
  parameter int         MAX_WORDS  = 64,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic        auUserClk,
  input  logic        auUserReset,
  input  logic [31:0] sAxisTdata,
  input  logic [3:0]  sAxisTkeep,
  input  logic [7:0]  sAxisTuser,
  input  logic        sAxisTlast,
  input  logic        sAxisTvalid,
  output logic [31:0] mAxisTdata,
  output logic        mAxisTlast,
  output logic        mAxisTvalid,
  input  logic        mAxisTready,
  output logic [15:0] goodPktCount,
  output logic [15:0] crcErrCount,
  output logic [15:0] framingErrCount,
  output logic [15:0] overflowCount,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [8:0]    MAX_N     = 9'(MAX_WORDS);
  localparam logic [PW:0]   DEPTH_EXT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Write side: wrCommit marks the end of committed data, wrSpec the end of
  // the packet currently being written speculatively.
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] r_wr_spec;
  logic [PW-1:0] r_rd_ptr;
  logic [7:0]    r_cnt;

  logic [32:0]   r_mem [DEPTH];
  logic [32:0]   r_mem_q;
  logic          r_rd_vld;

  // 2-entry output queue; head entry drives the output directly so the
  // presented word cannot change while it is stalled.
  logic [32:0]   r_q_word [2];
  logic          r_q_head;
  logic          r_q_tail;
  logic [1:0]    r_q_cnt;

  logic [15:0]   r_good_cnt;
  logic [15:0]   r_crc_cnt;
  logic [15:0]   r_frm_cnt;
  logic [15:0]   r_ovf_cnt;

  logic [7:0]    w_hdr_n;
  logic          w_keep_ok;
  logic          w_hdr_bad;
  logic [PW-1:0] w_occ;
  logic [PW:0]   w_free;
  logic [PW:0]   w_need;
  logic          w_no_space;
  logic          w_last_word;

  logic          w_mem_we;
  logic [32:0]   w_mem_wdata;
  logic          w_hdr_accept;
  logic          w_spec_inc;
  logic          w_commit;
  logic          w_rollback;
  logic          w_cnt_dec;
  logic          w_inc_good;
  logic          w_inc_crc;
  logic          w_inc_frm;
  logic          w_inc_ovf;

  logic          w_pop;
  logic          w_rd_issue;
  logic [1:0]    w_used;

  // Only the two CRC flag bits carry meaning.
  logic          w_unused_tuser;
  assign w_unused_tuser = ^sAxisTuser[7:2];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------- header
  assign w_hdr_n     = sAxisTdata[7:0];
  assign w_keep_ok   = (sAxisTkeep == 4'hF);
  assign w_hdr_bad   = !w_keep_ok
                     || (sAxisTdata[31:24] != MAGIC)
                     || (w_hdr_n == 8'd0)
                     || ({1'b0, w_hdr_n} > MAX_N)
                     || sAxisTlast;
  // Space is judged once, at header time, against committed data still in
  // memory; reads during the payload only ever make more room.
  assign w_occ       = r_wr_commit - r_rd_ptr;
  assign w_free      = DEPTH_EXT - {1'b0, w_occ};
  assign w_need      = (PW+1)'(w_hdr_n) + (PW+1)'(1);
  assign w_no_space  = (w_need > w_free);
  assign w_last_word = (r_cnt == 8'd1);

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge auUserClk) begin
    if (auUserReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_wdata  = {1'b0, sAxisTdata};
    w_hdr_accept = 1'b0;
    w_spec_inc   = 1'b0;
    w_commit     = 1'b0;
    w_rollback   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_inc_good   = 1'b0;
    w_inc_crc    = 1'b0;
    w_inc_frm    = 1'b0;
    w_inc_ovf    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sAxisTvalid) begin
          if (w_hdr_bad) begin
            w_inc_frm    = 1'b1;
            w_next_state = sAxisTlast ? S_IDLE : S_DROP;
          end else if (w_no_space) begin
            w_inc_ovf    = 1'b1;
            w_next_state = S_DROP;
          end else begin
            w_mem_we     = 1'b1;
            w_hdr_accept = 1'b1;
            w_spec_inc   = 1'b1;
            w_next_state = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (sAxisTvalid) begin
          // Writing an erroneous beat is harmless: it lands inside the space
          // reserved at header time and is discarded by the rollback.
          w_mem_we    = 1'b1;
          w_mem_wdata = {w_last_word, sAxisTdata};
          w_cnt_dec   = 1'b1;
          if (!w_keep_ok || (sAxisTlast && !w_last_word)) begin
            w_inc_frm    = 1'b1;
            w_rollback   = 1'b1;
            w_next_state = sAxisTlast ? S_IDLE : S_DROP;
          end else if (w_last_word && !sAxisTlast) begin
            w_inc_frm    = 1'b1;
            w_rollback   = 1'b1;
            w_next_state = S_DROP;
          end else if (w_last_word) begin
            if (sAxisTuser[1:0] == 2'b11) begin
              w_commit   = 1'b1;
              w_inc_good = 1'b1;
            end else begin
              w_inc_crc  = 1'b1;
              w_rollback = 1'b1;
            end
            w_next_state = S_IDLE;
          end else begin
            w_spec_inc = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (sAxisTvalid && sAxisTlast) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ write datapath
  always_ff @(posedge auUserClk) begin
    if (auUserReset) begin
      r_wr_commit <= '0;
      r_wr_spec   <= '0;
      r_cnt       <= '0;
      r_good_cnt  <= '0;
      r_crc_cnt   <= '0;
      r_frm_cnt   <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      if (w_commit) begin
        // The final beat is written this cycle, so the commit includes it.
        r_wr_commit <= r_wr_spec + PTR_ONE;
        r_wr_spec   <= r_wr_spec + PTR_ONE;
      end else if (w_rollback) begin
        r_wr_spec   <= r_wr_commit;
      end else if (w_spec_inc) begin
        r_wr_spec   <= r_wr_spec + PTR_ONE;
      end

      if (w_hdr_accept) begin
        r_cnt <= w_hdr_n;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 8'd1;
      end

      if (w_inc_good) r_good_cnt <= sat_inc(r_good_cnt);
      if (w_inc_crc)  r_crc_cnt  <= sat_inc(r_crc_cnt);
      if (w_inc_frm)  r_frm_cnt  <= sat_inc(r_frm_cnt);
      if (w_inc_ovf)  r_ovf_cnt  <= sat_inc(r_ovf_cnt);
    end
  end

  // --------------------------------------------------------------- memory
  // Reads only touch committed words and writes only the speculative region
  // beyond wrCommit, so the two ports never collide on an address.
  always_ff @(posedge auUserClk) begin
    if (w_mem_we) begin
      r_mem[r_wr_spec[ADDR_WIDTH-1:0]] <= w_mem_wdata;
    end
    if (w_rd_issue) begin
      r_mem_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  // ------------------------------------------------------------ read side
  assign mAxisTvalid = (r_q_cnt != 2'd0);
  assign w_pop       = mAxisTvalid && mAxisTready;
  // Queue entries plus the read in flight; a new read is issued only when
  // it is guaranteed a slot when its data returns.
  assign w_used      = r_q_cnt + {1'b0, r_rd_vld};
  assign w_rd_issue  = (r_rd_ptr != r_wr_commit) && ((w_used < 2'd2) || w_pop);

  always_ff @(posedge auUserClk) begin
    if (auUserReset) begin
      r_rd_ptr    <= '0;
      r_rd_vld    <= 1'b0;
      r_q_word[0] <= '0;
      r_q_word[1] <= '0;
      r_q_head    <= 1'b0;
      r_q_tail    <= 1'b0;
      r_q_cnt     <= 2'd0;
    end else begin
      r_rd_vld <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (r_rd_vld) begin
        r_q_word[r_q_tail] <= r_mem_q;
        r_q_tail           <= ~r_q_tail;
      end
      if (w_pop) begin
        r_q_head <= ~r_q_head;
      end
      r_q_cnt <= r_q_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

  assign mAxisTdata      = r_q_word[r_q_head][31:0];
  assign mAxisTlast      = r_q_word[r_q_head][32];

  assign goodPktCount    = r_good_cnt;
  assign crcErrCount     = r_crc_cnt;
  assign framingErrCount = r_frm_cnt;
  assign overflowCount   = r_ovf_cnt;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_cell_packet_receiver.sv
// tb/tb_cell_packet_receiver.sv - scoreboard bench for cell_packet_receiver
module tb_cell_packet_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sAxisTdata;
  logic [3:0]  sAxisTkeep;
  logic [7:0]  sAxisTuser;
  logic        sAxisTlast;
  logic        sAxisTvalid;
  logic [31:0] mAxisTdata;
  logic        mAxisTlast;
  logic        mAxisTvalid;
  logic        mAxisTready;
  logic [15:0] goodPktCount;
  logic [15:0] crcErrCount;
  logic [15:0] framingErrCount;
  logic [15:0] overflowCount;
  logic        busy;

  always #5 clk = ~clk;

  cell_packet_receiver #(
    .ADDR_WIDTH(9),
    .MAX_WORDS (64),
    .MAGIC     (8'hA5)
  ) dut (
    .auUserClk      (clk),
    .auUserReset    (rst),
    .sAxisTdata     (sAxisTdata),
    .sAxisTkeep     (sAxisTkeep),
    .sAxisTuser     (sAxisTuser),
    .sAxisTlast     (sAxisTlast),
    .sAxisTvalid    (sAxisTvalid),
    .mAxisTdata     (mAxisTdata),
    .mAxisTlast     (mAxisTlast),
    .mAxisTvalid    (mAxisTvalid),
    .mAxisTready    (mAxisTready),
    .goodPktCount   (goodPktCount),
    .crcErrCount    (crcErrCount),
    .framingErrCount(framingErrCount),
    .overflowCount  (overflowCount),
    .busy           (busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [7:0]  u;
    logic        l;
  } beat_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q [$];
  beat_t       pkt [$];
  int          committed_words = 0;
  int          popped_words = 0;
  int          exp_good = 0;
  int          exp_crc = 0;
  int          exp_frm = 0;
  int          exp_ovf = 0;
  int          rdy_mode = 1;
  bit          gaps_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ready driver: 0 = held low, 1 = held high, 2 = random
  initial begin
    mAxisTready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       mAxisTready = 1'b0;
        1:       mAxisTready = 1'b1;
        default: mAxisTready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // monitor: pops the scoreboard on each handshake and checks stall stability
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b1;
  logic [32:0] prev_word = '0;
  always @(negedge clk) begin
    logic [32:0] w;
    if (!rst && !prev_rst) begin
      if (prev_stall) begin
        check("hold_valid", {63'd0, mAxisTvalid}, 64'd1);
        check("hold_data", {31'd0, mAxisTlast, mAxisTdata}, {31'd0, prev_word});
      end
      if (mAxisTvalid && mAxisTready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_unexpected: got %0h want no output", {mAxisTlast, mAxisTdata});
        end else begin
          w = exp_q.pop_front();
          check("out_word", {31'd0, mAxisTlast, mAxisTdata}, {31'd0, w});
        end
        popped_words <= popped_words + 1;
      end
    end
    prev_rst   <= rst;
    prev_stall <= mAxisTvalid && !mAxisTready && !rst;
    prev_word  <= {mAxisTlast, mAxisTdata};
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_beat(input beat_t b);
    while (gaps_en && $urandom_range(0, 3) == 0) begin
      sAxisTvalid = 1'b0;
      sAxisTdata  = $urandom;
      sAxisTlast  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    sAxisTdata  = b.d;
    sAxisTkeep  = b.k;
    sAxisTuser  = b.u;
    sAxisTlast  = b.l;
    sAxisTvalid = 1'b1;
    @(posedge clk);
    #1;
    sAxisTvalid = 1'b0;
  endtask

  // header plus len payload beats; tlast only on the final beat (len==0: on header)
  task automatic make_pkt(input logic [31:0] h, input int len, input logic [3:0] hkeep,
                          input int bad_idx, input logic [7:0] user);
    beat_t b;
    pkt.delete();
    b.d = h;
    b.k = hkeep;
    b.u = (len == 0) ? user : 8'($urandom);
    b.l = (len == 0);
    pkt.push_back(b);
    for (int i = 1; i <= len; i++) begin
      b.d = $urandom;
      b.k = (i == bad_idx) ? 4'($urandom_range(0, 14)) : 4'hF;
      b.u = (i == len) ? user : 8'($urandom);
      b.l = (i == len);
      pkt.push_back(b);
    end
  endtask

  // Packet-level reference: decide the fate of the whole packet from the
  // header fields, payload length and keeps, then the final CRC flags.
  task automatic model_and_send();
    int n;
    int len;
    bit bad;
    n   = int'(pkt[0].d[7:0]);
    len = pkt.size() - 1;
    if (pkt[0].k != 4'hF || pkt[0].d[31:24] != 8'hA5 || n == 0 || n > 64 || pkt[0].l) begin
      exp_frm++;
    end else if (n + 1 > 512 - (committed_words - popped_words)) begin
      exp_ovf++;
    end else begin
      bad = (len != n);
      for (int i = 1; i <= len && i <= n; i++) begin
        if (pkt[i].k != 4'hF) bad = 1'b1;
      end
      if (bad) begin
        exp_frm++;
      end else if (pkt[len].u[1:0] == 2'b11) begin
        exp_good++;
        for (int i = 0; i <= n; i++) exp_q.push_back({i == n, pkt[i].d});
        committed_words += n + 1;
      end else begin
        exp_crc++;
      end
    end
    foreach (pkt[i]) drive_beat(pkt[i]);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (8) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_counters();
    check("good_cnt", {48'd0, goodPktCount}, 64'(exp_good));
    check("crc_cnt", {48'd0, crcErrCount}, 64'(exp_crc));
    check("frm_cnt", {48'd0, framingErrCount}, 64'(exp_frm));
    check("ovf_cnt", {48'd0, overflowCount}, 64'(exp_ovf));
    check("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int p0;
    beat_t b;
    rst         = 1'b1;
    sAxisTdata  = '0;
    sAxisTkeep  = 4'hF;
    sAxisTuser  = '0;
    sAxisTlast  = 1'b0;
    sAxisTvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, mAxisTvalid}, 64'd0);
    check("rst_data", {32'd0, mAxisTdata}, 64'd0);
    check("rst_last", {63'd0, mAxisTlast}, 64'd0);
    check_counters();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single good packet
    make_pkt(32'hA5030004, 4, 4'hF, 0, 8'h03);
    model_and_send();
    wait_drain("drain_good");
    check_counters();

    // bad CRC then good packet
    make_pkt(32'hA5030004, 4, 4'hF, 0, 8'h01);
    model_and_send();
    make_pkt(32'hA5030004, 4, 4'hF, 0, 8'h03);
    model_and_send();
    wait_drain("drain_crc");
    check_counters();

    // framing: bad magic, N=0, N=65, tlast on 3rd of 4
    make_pkt(32'h5A030004, 4, 4'hF, 0, 8'h03);
    model_and_send();
    check("idle_magic", {63'd0, busy}, 64'd0);
    make_pkt(32'hA5030000, 1, 4'hF, 0, 8'h03);
    model_and_send();
    check("idle_n0", {63'd0, busy}, 64'd0);
    make_pkt(32'hA5030041, 2, 4'hF, 0, 8'h03);
    model_and_send();
    check("idle_n65", {63'd0, busy}, 64'd0);
    make_pkt(32'hA5030004, 3, 4'hF, 0, 8'h03);
    model_and_send();
    check("idle_early", {63'd0, busy}, 64'd0);
    wait_drain("drain_frm");
    check_counters();

    // overflow with ready held low
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      make_pkt({8'hA5, 8'(i), 8'h00, 8'd64}, 64, 4'hF, 0, 8'h03);
      model_and_send();
    end
    check("ovf_held", {48'd0, overflowCount}, 64'(exp_ovf));
    check("ovf_good_held", {48'd0, goodPktCount}, 64'(exp_good));
    p0 = popped_words;
    rdy_mode = 1;
    wait_drain("drain_ovf");
    check("ovf_words_out", 64'(popped_words - p0), 64'd455);
    make_pkt({8'hA5, 8'h09, 8'h00, 8'd64}, 64, 4'hF, 0, 8'h03);
    model_and_send();
    wait_drain("drain_ninth");
    check_counters();

    // randomized traffic
    gaps_en  = 1'b1;
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      int kind;
      int n;
      int len;
      int bad;
      int need;
      int t;
      logic [7:0] mg;
      logic [7:0] usr;
      logic [3:0] hk;
      kind = $urandom_range(0, 14);
      n    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 64) : $urandom_range(1, 12);
      mg   = 8'hA5;
      hk   = 4'hF;
      bad  = 0;
      usr  = 8'($urandom) | 8'h03;
      len  = n;
      case (kind)
        6:  usr = {6'($urandom), 2'($urandom_range(0, 2))};
        7:  mg = 8'hA5 ^ (8'd1 << $urandom_range(0, 7));
        8:  begin n = 0; len = $urandom_range(1, 4); end
        9:  begin n = $urandom_range(65, 255); len = $urandom_range(1, 4); end
        10: len = 0;
        11: bad = $urandom_range(1, n);
        12: begin if (n < 2) n = 2; len = $urandom_range(1, n - 1); end
        13: len = n + $urandom_range(1, 3);
        14: hk = 4'($urandom_range(0, 14));
        default: ;
      endcase
      need = (n >= 1 && n <= 64) ? n + 1 : 1;
      t = 0;
      while ((committed_words - popped_words) + need > 512 && t < 5000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 5000) begin
        n_checks++;
        n_errors++;
        $display("FAIL space_wait: got occupancy %0d want room for %0d", committed_words - popped_words, need);
      end
      make_pkt({mg, 8'($urandom), 8'($urandom), 8'(n)}, len, hk, bad, usr);
      model_and_send();
    end
    gaps_en  = 1'b0;
    rdy_mode = 1;
    wait_drain("drain_random");
    check_counters();

    // reset mid-payload with committed data pending
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    make_pkt(32'hA5070004, 4, 4'hF, 0, 8'h03);
    model_and_send();
    repeat (6) @(posedge clk);
    #1;
    check("pending_valid", {63'd0, mAxisTvalid}, 64'd1);
    b.k = 4'hF;
    b.u = 8'h00;
    b.l = 1'b0;
    b.d = 32'hA5080004;
    drive_beat(b);
    b.d = 32'h11112222;
    drive_beat(b);
    b.d = 32'h33334444;
    drive_beat(b);
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    exp_good = 0;
    exp_crc  = 0;
    exp_frm  = 0;
    exp_ovf  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    committed_words = popped_words;
    check("midrst_valid", {63'd0, mAxisTvalid}, 64'd0);
    check_counters();
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    make_pkt(32'hA5090003, 3, 4'hF, 0, 8'h03);
    model_and_send();
    wait_drain("drain_after_rst");
    check_counters();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
